// File: rtl/msk_rnd_source.sv
// Fresh-randomness source: 80-bit Fibonacci LFSR seeded over five 16-bit words, warmed up, then RND_W bits per accepted cycle.
// rnd_out is registered and holds while rnd_ready is low; seed_ready decodes the EMPTY state only.
module msk_rnd_source #(
    parameter int d      = 2,
    parameter int RND_W  = d * (d - 1) / 2,
    parameter int WARMUP = 160
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      seed_data,
    input  logic             seed_valid,
    output logic             seed_ready,
    input  logic             reseed,
    output logic [RND_W-1:0] rnd_out,
    output logic             rnd_valid,
    input  logic             rnd_ready,
    output logic             seed_zero
);
    localparam int WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

    typedef enum logic [1:0] {S_EMPTY, S_WARM, S_RUN} state_t;

    state_t           state_q, state_d;
    logic [79:0]      lfsr_q, lfsr_d;
    logic [2:0]       wcnt_q, wcnt_d;
    logic [WCW-1:0]   warm_q, warm_d;
    logic [RND_W-1:0] rnd_out_q, rnd_out_d;
    logic             rnd_valid_q, rnd_valid_d;
    logic             seed_zero_q, seed_zero_d;

    logic [79:0]      adv_s;
    logic [RND_W-1:0] adv_bits;
    logic [79:0]      seed_cat;

    function automatic logic [79:0] lfsr_step(input logic [79:0] s);
        return {s[78:0], s[79] ^ s[78] ^ s[42] ^ s[41]};
    endfunction

    // RND_W steps unrolled; bit k is the bit shifted out by step k.
    always_comb begin
        adv_s    = lfsr_q;
        adv_bits = '0;
        for (int k = 0; k < RND_W; k++) begin
            adv_bits[k] = adv_s[79];
            adv_s       = lfsr_step(adv_s);
        end
    end

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        wcnt_d      = wcnt_q;
        warm_d      = warm_q;
        rnd_out_d   = rnd_out_q;
        rnd_valid_d = rnd_valid_q;
        seed_zero_d = seed_zero_q;
        seed_cat    = lfsr_q;
        seed_cat[{wcnt_q, 4'b0000} +: 16] = seed_data;

        if (reseed) begin
            state_d     = S_EMPTY;
            wcnt_d      = '0;
            warm_d      = '0;
            rnd_out_d   = '0;
            rnd_valid_d = 1'b0;
            seed_zero_d = 1'b0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (seed_valid) begin
                        lfsr_d = seed_cat;
                        wcnt_d = wcnt_q + 3'd1;
                        if (wcnt_q == 3'd4) begin
                            wcnt_d  = '0;
                            warm_d  = '0;
                            state_d = (WARMUP == 0) ? S_RUN : S_WARM;
                            // An all-zero LFSR would lock up; substitute a nonzero state.
                            if (seed_cat == '0) begin
                                lfsr_d      = 80'h1;
                                seed_zero_d = 1'b1;
                            end
                        end
                    end
                end
                S_WARM: begin
                    lfsr_d = adv_s;
                    warm_d = warm_q + 1'b1;
                    if (warm_q == WCW'(WARMUP - 1)) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (!rnd_valid_q || rnd_ready) begin
                        lfsr_d      = adv_s;
                        rnd_out_d   = adv_bits;
                        rnd_valid_d = 1'b1;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            lfsr_q      <= '0;
            wcnt_q      <= '0;
            warm_q      <= '0;
            rnd_out_q   <= '0;
            rnd_valid_q <= 1'b0;
            seed_zero_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            wcnt_q      <= wcnt_d;
            warm_q      <= warm_d;
            rnd_out_q   <= rnd_out_d;
            rnd_valid_q <= rnd_valid_d;
            seed_zero_q <= seed_zero_d;
        end
    end

    assign seed_ready = (state_q == S_EMPTY);
    assign rnd_out    = rnd_out_q;
    assign rnd_valid  = rnd_valid_q;
    assign seed_zero  = seed_zero_q;

endmodule
